// File: rtl/mod_148_4_5_plca_data_tx.sv
// PLCA Data transmit-side FSM: defers the MAC, drives COMMIT and runs the commit/pending timers.
// Optional `MOD_148_TIMER_DEBUG_EN exposes the timer done/not_done status outputs.
module mod_148_4_5_plca_data_tx #(
  parameter int unsigned COMMIT_CYCLES  = 720,
  parameter int unsigned PENDING_CYCLES = 1280,
  parameter int unsigned CNT_W          = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       plca_en,
  input  logic       tx_opportunity,
  input  logic       mac_tx_en,
  input  logic [3:0] mac_txd,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  output logic [3:0] phy_txd,
  output logic       mac_crs,
  output logic       mac_col,
  output logic       packet_pending,
`ifdef MOD_148_TIMER_DEBUG_EN
  output logic       commit_timer_done,
  output logic       commit_timer_not_done,
  output logic       pending_timer_done,
  output logic       pending_timer_not_done,
`endif
  output logic       committed
);

  typedef enum logic [2:0] {
    StNormal,
    StIdle,
    StCollide,
    StPending,
    StCommit,
    StTransmit
  } state_e;

  localparam logic [CNT_W-1:0] CommitLast  = CNT_W'(COMMIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PendingLast = CNT_W'(PENDING_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [3:0]       CommitSym   = 4'b0011;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_commit_cnt, w_commit_cnt_d;
  logic [CNT_W-1:0] r_pending_cnt, w_pending_cnt_d;

  logic       w_tx_en_d, w_tx_er_d, w_crs_d, w_col_d, w_pending_d, w_committed_d;
  logic [3:0] w_txd_d;
  logic       w_commit_done_d, w_pending_done_d;

  // Next state first, then outputs decoded from the state being entered so every
  // output register reflects the new state on the same edge.
  always_comb begin
    w_state_d        = r_state;
    w_commit_done_d  = 1'b0;
    w_pending_done_d = 1'b0;
    if (!plca_en) begin
      w_state_d = StNormal;
    end else begin
      unique case (r_state)
        StNormal:   if (!mac_tx_en) w_state_d = StIdle;
        StIdle:     if (mac_tx_en) w_state_d = tx_opportunity ? StTransmit : StCollide;
        StCollide:  if (!mac_tx_en) w_state_d = StPending;
        StPending: begin
          if (tx_opportunity) begin
            w_state_d = StCommit;
          end else if (r_pending_cnt == PendingLast) begin
            w_state_d        = StIdle;
            w_pending_done_d = 1'b1;
          end
        end
        StCommit: begin
          if (mac_tx_en) begin
            w_state_d = StTransmit;
          end else if (r_commit_cnt == CommitLast) begin
            w_state_d       = StIdle;
            w_commit_done_d = 1'b1;
          end
        end
        StTransmit: if (!mac_tx_en) w_state_d = StIdle;
        default:    w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_tx_en_d       = 1'b0;
    w_tx_er_d       = 1'b0;
    w_txd_d         = 4'b0000;
    w_crs_d         = 1'b0;
    w_col_d         = 1'b0;
    w_pending_d     = 1'b0;
    w_committed_d   = 1'b0;
    w_commit_cnt_d  = '0;
    w_pending_cnt_d = '0;
    unique case (w_state_d)
      StNormal: begin
        w_tx_en_d = mac_tx_en;
        w_txd_d   = mac_txd;
      end
      StIdle: begin
      end
      StCollide: begin
        w_crs_d = 1'b1;
        w_col_d = 1'b1;
      end
      StPending: begin
        w_pending_d = 1'b1;
        w_crs_d     = 1'b1;
        if (r_state == StPending) begin
          w_pending_cnt_d = (r_pending_cnt == CntMax) ? r_pending_cnt
                                                       : r_pending_cnt + CNT_W'(1);
        end
      end
      StCommit: begin
        w_committed_d = 1'b1;
        w_tx_er_d     = 1'b1;
        w_txd_d       = CommitSym;
        if (r_state == StCommit) begin
          w_commit_cnt_d = (r_commit_cnt == CntMax) ? r_commit_cnt
                                                     : r_commit_cnt + CNT_W'(1);
        end
      end
      StTransmit: begin
        w_tx_en_d     = mac_tx_en;
        w_txd_d       = mac_txd;
        w_crs_d       = 1'b1;
        w_committed_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_commit_cnt   <= '0;
      r_pending_cnt  <= '0;
      phy_tx_en      <= 1'b0;
      phy_tx_er      <= 1'b0;
      phy_txd        <= 4'b0000;
      mac_crs        <= 1'b0;
      mac_col        <= 1'b0;
      packet_pending <= 1'b0;
      committed      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_commit_cnt   <= w_commit_cnt_d;
      r_pending_cnt  <= w_pending_cnt_d;
      phy_tx_en      <= w_tx_en_d;
      phy_tx_er      <= w_tx_er_d;
      phy_txd        <= w_txd_d;
      mac_crs        <= w_crs_d;
      mac_col        <= w_col_d;
      packet_pending <= w_pending_d;
      committed      <= w_committed_d;
    end
  end

`ifdef MOD_148_TIMER_DEBUG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_timer_done      <= 1'b0;
      commit_timer_not_done  <= 1'b0;
      pending_timer_done     <= 1'b0;
      pending_timer_not_done <= 1'b0;
    end else begin
      commit_timer_done      <= w_commit_done_d;
      commit_timer_not_done  <= (w_state_d == StCommit);
      pending_timer_done     <= w_pending_done_d;
      pending_timer_not_done <= (w_state_d == StPending);
    end
  end
`else
  logic w_unused_done;
  assign w_unused_done = w_commit_done_d ^ w_pending_done_d;
`endif

endmodule

// File: tb/tb_mod_148_4_5_plca_data_tx.sv
// Scoreboard bench for mod_148_4_5_plca_data_tx: directed steps push expected output vectors,
// a monitor pops and compares one vector per clock.
module tb_mod_148_4_5_plca_data_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       plca_en = 1'b0;
  logic       tx_opportunity = 1'b0;
  logic       mac_tx_en = 1'b0;
  logic [3:0] mac_txd = 4'h0;
  logic       phy_tx_en, phy_tx_er, mac_crs, mac_col, packet_pending, committed;
  logic [3:0] phy_txd;
`ifdef MOD_148_TIMER_DEBUG_EN
  logic commit_timer_done, commit_timer_not_done, pending_timer_done, pending_timer_not_done;
  int   n_commit_done = 0;
  int   n_pending_done = 0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Vector layout: {tx_en, tx_er, txd[3:0], crs, col, pending, committed}
  localparam logic [9:0] EIdle   = 10'b00_0000_0000;
  localparam logic [9:0] ECol    = 10'b00_0000_1100;
  localparam logic [9:0] EPend   = 10'b00_0000_1010;
  localparam logic [9:0] ECommit = 10'b01_0011_0001;

  logic [9:0] q_exp[$];
  string      q_name[$];

  mod_148_4_5_plca_data_tx dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .plca_en                (plca_en),
    .tx_opportunity         (tx_opportunity),
    .mac_tx_en              (mac_tx_en),
    .mac_txd                (mac_txd),
    .phy_tx_en              (phy_tx_en),
    .phy_tx_er              (phy_tx_er),
    .phy_txd                (phy_txd),
    .mac_crs                (mac_crs),
    .mac_col                (mac_col),
    .packet_pending         (packet_pending),
`ifdef MOD_148_TIMER_DEBUG_EN
    .commit_timer_done      (commit_timer_done),
    .commit_timer_not_done  (commit_timer_not_done),
    .pending_timer_done     (pending_timer_done),
    .pending_timer_not_done (pending_timer_not_done),
`endif
    .committed              (committed)
  );

  always #20 clk = ~clk;

  function automatic logic [9:0] e_tx(input logic [3:0] d);
    return {1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic logic [9:0] e_norm(input logic en, input logic [3:0] d);
    return {en, 1'b0, d, 4'b0000};
  endfunction

  function automatic logic [9:0] actual();
    return {phy_tx_en, phy_tx_er, phy_txd, mac_crs, mac_col, packet_pending, committed};
  endfunction

  task automatic check(input string nm, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic p, input logic o, input logic e, input logic [3:0] d,
                      input logic [9:0] x, input string nm);
    @(negedge clk);
    plca_en        = p;
    tx_opportunity = o;
    mac_tx_en      = e;
    mac_txd        = d;
    q_exp.push_back(x);
    q_name.push_back(nm);
  endtask

  task automatic enter_pending(input string nm);
    step(1, 0, 1, 4'h1, ECol, {nm, "_col"});
    step(1, 0, 0, 4'h0, EPend, {nm, "_pend_entry"});
  endtask

  // Monitor: one expected vector per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (q_exp.size() != 0) begin
      logic [9:0] x;
      string      nm;
      x  = q_exp.pop_front();
      nm = q_name.pop_front();
      check(nm, actual(), x);
    end
  end

`ifdef MOD_148_TIMER_DEBUG_EN
  always @(posedge clk) begin
    #1;
    if (commit_timer_done) n_commit_done++;
    if (pending_timer_done) n_pending_done++;
  end
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #5;
    check("reset_state", actual(), EIdle);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // plca_en=0: pure pass-through, opportunity ignored.
    step(0, 0, 0, 4'h0, EIdle, "norm_idle");
    step(0, 0, 1, 4'h5, e_norm(1, 4'h5), "norm_d5");
    step(0, 1, 1, 4'hA, e_norm(1, 4'hA), "norm_dA");
    step(0, 1, 0, 4'h0, EIdle, "norm_end");
    step(1, 0, 0, 4'h0, EIdle, "norm_to_idle");

    // Granted 64-nibble frame; opportunity drops halfway and is ignored.
    for (int i = 0; i < 64; i++) begin
      step(1, (i < 32), 1, 4'(i), e_tx(4'(i)), "grant_frame");
    end
    step(1, 0, 0, 4'h0, EIdle, "grant_end");

    // Deferral: collision, 100 pending cycles, grant, 10 cycles of COMMIT, data follows.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'h7, ECol, "defer_col");
    step(1, 0, 0, 4'h0, EPend, "defer_pend_entry");
    for (int i = 0; i < 99; i++) step(1, 0, 0, 4'h0, EPend, "defer_pend");
    step(1, 1, 0, 4'h0, ECommit, "defer_commit_entry");
    for (int i = 0; i < 9; i++) step(1, 0, 0, 4'h0, ECommit, "defer_commit");
    step(1, 0, 1, 4'h9, e_tx(4'h9), "defer_tx_first");
    step(1, 0, 1, 4'h4, e_tx(4'h4), "defer_tx_second");
    step(1, 0, 0, 4'h0, EIdle, "defer_end");

    // Pending timeout: pending visible 1280 cycles, gone on cycle 1281.
    enter_pending("ptmo");
    for (int i = 0; i < 1279; i++) step(1, 0, 0, 4'h0, EPend, "ptmo_pend");
    step(1, 0, 0, 4'h0, EIdle, "ptmo_expired");
    step(1, 0, 0, 4'h0, EIdle, "ptmo_idle");

    // Opportunity on the expiry cycle wins, then commit timer runs out.
    enter_pending("powin");
    for (int i = 0; i < 1279; i++) step(1, 0, 0, 4'h0, EPend, "powin_pend");
    step(1, 1, 0, 4'h0, ECommit, "powin_commit_entry");
    for (int i = 0; i < 719; i++) step(1, 0, 0, 4'h0, ECommit, "ctmo_commit");
    step(1, 0, 0, 4'h0, EIdle, "ctmo_expired");

    // mac_tx_en on the commit expiry cycle wins.
    enter_pending("cwin");
    step(1, 1, 0, 4'h0, ECommit, "cwin_commit_entry");
    for (int i = 0; i < 719; i++) step(1, 0, 0, 4'h0, ECommit, "cwin_commit");
    step(1, 0, 1, 4'h6, e_tx(4'h6), "cwin_tx");
    step(1, 0, 0, 4'h0, EIdle, "cwin_end");

    // Asynchronous reset in the middle of a granted frame.
    step(1, 1, 1, 4'h2, e_tx(4'h2), "rst_tx_a");
    step(1, 1, 1, 4'h3, e_tx(4'h3), "rst_tx_b");
    @(posedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_frame", actual(), EIdle);
    @(negedge clk);
    tx_opportunity = 1'b0;
    mac_tx_en      = 1'b0;
    mac_txd        = 4'h0;
    #1;
    check("reset_held", actual(), EIdle);
    reset_n = 1'b1;
    step(1, 0, 0, 4'h0, EIdle, "post_reset_idle");
    step(1, 1, 1, 4'h8, e_tx(4'h8), "post_reset_tx");
    step(1, 0, 0, 4'h0, EIdle, "post_reset_end");

    repeat (3) @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q_exp.size());
    end
`ifdef MOD_148_TIMER_DEBUG_EN
    n_checks++;
    if (n_commit_done != 1) begin
      n_fail++;
      $display("FAIL commit_done_pulses: got %0d expected 1", n_commit_done);
    end
    n_checks++;
    if (n_pending_done != 1) begin
      n_fail++;
      $display("FAIL pending_done_pulses: got %0d expected 1", n_pending_done);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
